// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl -- programmable integer clock divider with glitch-free ratio
// changes.
//
// The divide ratio (cur_div) changes only at a period boundary, so clk_out
// never carries a truncated or runt pulse. A ratio request that arrives
// mid-period is parked in pend_div_q (state PEND) until the wrap.
//
// Parameters:
//   W        width of the divide ratio and of the period counter
//   DEF_DIV  divide ratio loaded at reset (legal range 2..2^W-1)
//
// Ports:
//   clk        in   single rising-edge clock
//   rst_n      in   synchronous active-low reset
//   div_en     in   run request; 0 stops at the end of the current period
//   req_valid  in   ratio-change request valid
//   req_div    in   requested divide ratio (W bits)
//   req_ready  out  controller can accept a ratio request (low in PEND)
//   err        out  one-cycle pulse: requested ratio < 2 was rejected
//   busy       out  a ratio change is pending (PEND)
//   cur_div    out  ratio currently in effect (W bits)
//   clk_out    out  divided clock level
//   tick       out  one-cycle pulse at the start of each output period
module clk_div_ctrl #(
  parameter int W       = 4,
  parameter int DEF_DIV = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         div_en,
  input  logic         req_valid,
  input  logic [W-1:0] req_div,
  output logic         req_ready,
  output logic         err,
  output logic         busy,
  output logic [W-1:0] cur_div,
  output logic         clk_out,
  output logic         tick
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  logic [1:0]   state_q,   state_d;
  logic [W-1:0] cnt_q,     cnt_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         err_q,     err_d;

  logic         accept;
  logic         legal;
  logic         boundary;

  assign accept   = req_valid && (state_q != PEND);
  assign legal    = (req_div >= W'(2));
  assign boundary = (state_q != IDLE) && (cnt_q == (cur_div_q - W'(1)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    err_d      = accept && !legal;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept && legal) cur_div_d = req_div;
        if (div_en) state_d = RUN;
      end
      RUN: begin
        if (boundary) begin
          cnt_d = '0;
          // A request landing on the wrap is applied right here, skipping PEND.
          if (accept && legal) cur_div_d = req_div;
          state_d = div_en ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + W'(1);
          if (accept && legal) begin
            pend_div_d = req_div;
            state_d    = PEND;
          end
        end
      end
      PEND: begin
        if (boundary) begin
          cnt_d     = '0;
          cur_div_d = pend_div_q;
          state_d   = div_en ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_div_q  <= W'(DEF_DIV);
      pend_div_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      err_q      <= err_d;
    end
  end

  // Outputs decode registered state only.
  assign req_ready = (state_q != PEND);
  assign busy      = (state_q == PEND);
  assign err       = err_q;
  assign cur_div   = cur_div_q;
  assign clk_out   = (state_q != IDLE) && (cnt_q < (cur_div_q >> 1));
  assign tick      = (state_q != IDLE) && (cnt_q == '0);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: directed scenarios followed by random stimulus.
// A behavioural model (running flag, position in period, ratio, parked
// ratio) predicts outputs each cycle and pushes them to a queue; a monitor
// on the falling edge pops and compares against the DUT.
module tb_clk_div_ctrl;

  localparam int W       = 4;
  localparam int DEF_DIV = 3;

  logic         clk;
  logic         rst_n;
  logic         div_en;
  logic         req_valid;
  logic [W-1:0] req_div;
  logic         req_ready;
  logic         err;
  logic         busy;
  logic [W-1:0] cur_div;
  logic         clk_out;
  logic         tick;

  clk_div_ctrl #(.W(W), .DEF_DIV(DEF_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_en    (div_en),
    .req_valid (req_valid),
    .req_div   (req_div),
    .req_ready (req_ready),
    .err       (err),
    .busy      (busy),
    .cur_div   (cur_div),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         clk_out;
    logic         tick;
    logic         req_ready;
    logic         busy;
    logic         err;
    logic [W-1:0] cur_div;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state
  bit m_run   = 1'b0;
  int m_pos   = 0;
  int m_ratio = DEF_DIV;
  int m_pend  = -1;   // -1: no parked ratio
  bit m_err   = 1'b0;

  always @(posedge clk) begin
    bit   acc, ok, at_end;
    exp_t e;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_ratio = DEF_DIV; m_pend = -1; m_err = 0;
    end else begin
      acc    = req_valid && (m_pend < 0);
      ok     = (int'(req_div) >= 2);
      at_end = m_run && (m_pos == m_ratio - 1);
      if (!m_run) begin
        if (acc && ok) m_ratio = int'(req_div);
        if (div_en) begin m_run = 1; m_pos = 0; end
      end else if (at_end) begin
        m_pos = 0;
        if (m_pend >= 0) begin m_ratio = m_pend; m_pend = -1; end
        else if (acc && ok) m_ratio = int'(req_div);
        m_run = div_en;
      end else begin
        m_pos++;
        if (acc && ok) m_pend = int'(req_div);
      end
      m_err = acc && !ok;
    end
    e.clk_out   = m_run && (m_pos < m_ratio / 2);
    e.tick      = m_run && (m_pos == 0);
    e.req_ready = (m_pend < 0);
    e.busy      = (m_pend >= 0);
    e.err       = m_err;
    e.cur_div   = W'(m_ratio);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{clk_out: clk_out, tick: tick, req_ready: req_ready,
            busy: busy, err: err, cur_div: cur_div};
      n_total++;
      if (a == e) n_pass++;
      else $display("FAIL outputs t=%0t: got clk_out=%b tick=%b ready=%b busy=%b err=%b cur_div=%0d, expected clk_out=%b tick=%b ready=%b busy=%b err=%b cur_div=%0d",
                    $time, a.clk_out, a.tick, a.req_ready, a.busy, a.err, a.cur_div,
                    e.clk_out, e.tick, e.req_ready, e.busy, e.err, e.cur_div);
    end
  end

  // Apply inputs for one cycle, starting at a falling edge.
  task automatic step(input logic en, input logic v, input logic [W-1:0] d,
                      input logic rn = 1'b1);
    rst_n = rn; div_en = en; req_valid = v; req_div = d;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(div_en, 1'b0, '0);
  endtask

  // Hold div_en until the model is at position p of a running period.
  task automatic wait_pos(input int p);
    int k = 0;
    while (!(m_run && m_pos == p) && k < 40) begin
      step(div_en, 1'b0, '0);
      k++;
    end
    if (!(m_run && m_pos == p)) begin
      n_total++;
      $display("FAIL wait_pos: position %0d not reached, got %0d", p, m_pos);
    end
  endtask

  initial begin
    rst_n = 1'b0; div_en = 1'b0; req_valid = 1'b0; req_div = '0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
    run(2);
    // Start at the default ratio
    step(1'b1, 1'b0, '0);
    run(10);
    // Ratio change to 6 mid-period
    wait_pos(1);
    step(1'b1, 1'b1, W'(6));
    run(16);
    // Illegal ratios rejected
    step(1'b1, 1'b1, W'(1));
    run(3);
    step(1'b1, 1'b1, W'(0));
    run(8);
    // Change to 5, then stop at a period start
    wait_pos(2);
    step(1'b1, 1'b1, W'(5));
    run(8);
    wait_pos(0);
    step(1'b0, 1'b0, '0);
    run(8);
    step(1'b1, 1'b0, '0);
    run(6);
    // Back to 3, then request 4 on a boundary cycle
    wait_pos(1);
    step(1'b1, 1'b1, W'(3));
    run(6);
    wait_pos(2);
    step(1'b1, 1'b1, W'(4));
    run(10);
    // Request equal to the current ratio
    wait_pos(1);
    step(1'b1, 1'b1, W'(4));
    run(6);
    // Reset while a change to 8 is parked
    wait_pos(1);
    step(1'b1, 1'b1, W'(8));
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0);
    run(12);
    // Ratio change while idle, then random traffic
    step(1'b0, 1'b0, '0);
    run(4);
    step(1'b0, 1'b1, W'(7));
    run(2);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
           W'($urandom_range(0, 15)), ($urandom_range(0, 199) != 0));
    end
    run(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter W, default 4: width of the divide ratio and the period counter.
REQ-002 Parameter DEF_DIV, default 3: divide ratio loaded at reset; legal range 2..2^W-1.
REQ-003 clk  input  1: single clock; every flop is rising-edge.
REQ-004 rst_n  input  1: reset, synchronous, active-low.
REQ-005 div_en  input  1: run request; 1 = generate divided clock, 0 = stop at the end of the current period.
REQ-006 req_valid  input  1: ratio-change request valid.
REQ-007 req_div  input  W: requested divide ratio.
REQ-008 req_ready  output  1: controller can accept a ratio request.
REQ-009 err  output  1: one-cycle pulse; illegal ratio rejected.
REQ-010 busy  output  1: a ratio change is pending.
REQ-011 cur_div  output  W: ratio currently in effect.
REQ-012 clk_out  output  1: divided clock level.
REQ-013 tick  output  1: one-cycle pulse marking the start of each output period.

Function
REQ-014 FSM states: IDLE (stopped), RUN (dividing), PEND (dividing, ratio change waiting for period end).
REQ-015 Counter cnt, W bits, counts 0..cur_div-1 in RUN/PEND and wraps to 0; the wrap cycle (cnt==cur_div-1) is the period boundary.
REQ-016 clk_out = (state!=IDLE) && (cnt < cur_div>>1); tick = (state!=IDLE) && (cnt==0); both decode registers only, with no input-to-output path.
REQ-017 Resulting duty: even N gives exactly 50%; odd N gives high floor(N/2), low ceil(N/2) cycles.
REQ-018 IDLE with div_en=1 goes to RUN next cycle with cnt=0, so tick and clk_out rise one cycle after div_en is sampled high.
REQ-019 In RUN/PEND, div_en sampled 0 on a boundary cycle goes to IDLE with cnt=0; div_en=0 elsewhere has no effect until the boundary, so a period is never truncated.
REQ-020 req_ready = 1 in IDLE and RUN, 0 in PEND; a request is accepted on req_valid && req_ready.
REQ-021 An accepted req_div < 2 is consumed with no state change; err pulses high for exactly one cycle on the following cycle.
REQ-022 An accepted legal request in IDLE updates cur_div on the next cycle and stays in IDLE.
REQ-023 An accepted legal request in RUN on a non-boundary cycle latches pend_div and goes to PEND; busy=1 while in PEND.
REQ-024 In PEND, at the boundary: cur_div<=pend_div and cnt<=0; the next state is RUN if div_en=1, else IDLE. The new ratio takes effect from the next tick.
REQ-025 An accepted legal request on a RUN boundary cycle is applied at that same wrap and does not enter PEND.
REQ-026 A request equal to cur_div is handled exactly like any other legal request.
REQ-027 cur_div never changes mid-period while clk_out is running; clk_out has no pulse shorter than one clk cycle.

Reset
REQ-028 rst_n=0 at a rising edge sets the following on the next cycle: state=IDLE, cnt=0, cur_div=DEF_DIV, pending request discarded, clk_out=0, tick=0, err=0, busy=0, req_ready=1.
REQ-029 Reset mid-period or while in PEND obeys REQ-028 with no completion of the current period.

Verification
REQ-030 Reset, then div_en=1, DEF_DIV=3: tick one cycle later and then every 3 cycles; clk_out pattern 1,0,0 repeating.
REQ-031 Running at N=3, request div=6 at cnt=1: req_ready=0 and busy=1 until the wrap; then tick every 6 cycles, clk_out 1,1,1,0,0,0, cur_div=6.
REQ-032 Request div=1 in RUN: err=1 for one cycle, cur_div stays 3, period unchanged, req_ready stays 1.
REQ-033 N=5, div_en drops at cnt=0: 4 more cycles run, then IDLE with clk_out=0 and no further tick; div_en=1 restarts with a tick one cycle later.
REQ-034 Request div=4 on a boundary cycle at N=3: the next period is 4 cycles, busy never asserts.
REQ-035 rst_n low while in PEND with a pending div=8: next cycle shows all REQ-028 values, cur_div=3, and no later switch to 8.
